// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the stack-machine cpu.
//   phase_e     - sequencer phase (FETCH, EXEC, LOAD, HALT)
//   OP_*        - primary opcodes (instr[14:12] when instr[15]=0)
//   FN_*        - ALU function codes (instr[3:0] of op 0)
//   stk_eff_t   - stack effect of an operation: pop count, push, swap
//   sext15      - sign-extend a 15-bit PUSH immediate to 16 bits
package cpu_pkg;

    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_EXEC  = 2'd1,
        PH_LOAD  = 2'd2,
        PH_HALT  = 2'd3
    } phase_e;

    localparam logic [2:0] OP_ALU  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JZ   = 3'd2;
    localparam logic [2:0] OP_LD   = 3'd3;
    localparam logic [2:0] OP_ST   = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_STI  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [3:0] FN_NOP  = 4'h0;
    localparam logic [3:0] FN_ADD  = 4'h1;
    localparam logic [3:0] FN_SUB  = 4'h2;
    localparam logic [3:0] FN_AND  = 4'h3;
    localparam logic [3:0] FN_OR   = 4'h4;
    localparam logic [3:0] FN_XOR  = 4'h5;
    localparam logic [3:0] FN_NOT  = 4'h6;
    localparam logic [3:0] FN_SHL  = 4'h7;
    localparam logic [3:0] FN_SHR  = 4'h8;
    localparam logic [3:0] FN_EQ   = 4'h9;
    localparam logic [3:0] FN_LT   = 4'hA;
    localparam logic [3:0] FN_DUP  = 4'hB;
    localparam logic [3:0] FN_DROP = 4'hC;
    localparam logic [3:0] FN_SWAP = 4'hD;

    localparam logic [9:0] DEFAULT_RESET_PC = 10'h100;

    // Stack effect applied in this order: pop pop_cnt entries, then push
    // the result if push=1. swap exchanges the two top entries instead.
    typedef struct packed {
        logic [1:0] pop_cnt;
        logic       push;
        logic       swap;
    } stk_eff_t;

    function automatic logic [15:0] sext15(input logic [14:0] v);
        return {v[14], v};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for op 0 instructions.
//   a      in  16  second stack entry (stack[1])
//   b      in  16  top of stack (stack[0])
//   func   in  4   function code
//   result out 16  value to push (when eff.push=1)
//   eff    out     stack effect the sequencer must apply
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  func,
    output logic [15:0] result,
    output stk_eff_t    eff
);

    localparam stk_eff_t EFF_BIN = '{pop_cnt: 2'd2, push: 1'b1, swap: 1'b0};

    always_comb begin
        result = '0;
        eff    = '0;
        case (func)
            FN_ADD: begin result = a + b;  eff = EFF_BIN; end
            FN_SUB: begin result = a - b;  eff = EFF_BIN; end
            FN_AND: begin result = a & b;  eff = EFF_BIN; end
            FN_OR:  begin result = a | b;  eff = EFF_BIN; end
            FN_XOR: begin result = a ^ b;  eff = EFF_BIN; end
            FN_SHL: begin result = a << b[3:0]; eff = EFF_BIN; end
            FN_SHR: begin result = a >> b[3:0]; eff = EFF_BIN; end
            FN_EQ:  begin result = {15'h0, a == b}; eff = EFF_BIN; end
            FN_LT:  begin result = {15'h0, $signed(a) < $signed(b)}; eff = EFF_BIN; end
            FN_NOT: begin
                // replace top: pop one, push the inverted value
                result      = ~b;
                eff.pop_cnt = 2'd1;
                eff.push    = 1'b1;
            end
            FN_DUP: begin
                result   = b;
                eff.push = 1'b1;
            end
            FN_DROP: eff.pop_cnt = 2'd1;
            FN_SWAP: eff.swap    = 1'b1;
            default: ;  // NOP, E, F
        endcase
    end

endmodule

// File: rtl/cpu.sv
// cpu: stack-machine processor, 16-bit instructions/data, 10-bit word
// address space shared by program and data. Single-port synchronous memory
// with one-cycle read latency.
//   clk      in  1   clock, all state on posedge
//   rst      in  1   synchronous active-high reset
//   mem_addr out 10  fetch / load / store address
//   rd_data  in  16  memory read data (one cycle after mem_addr)
//   wr_data  out 16  store data, valid while mem_wr=1
//   mem_wr   out 1   write strobe
module cpu
    import cpu_pkg::*;
#(
    parameter logic [9:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int         STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  mem_addr,
    input  logic [15:0] rd_data,
    output logic [15:0] wr_data,
    output logic        mem_wr
);

    typedef logic [STACK_DEPTH-1:0][15:0] stack_t;

    logic [9:0]  pc_q, pc_d;
    phase_e      phase_q, phase_d;
    logic [15:0] ir_q, ir_d;
    stack_t      stack_q, stack_d;

    logic [15:0] instr;
    logic [2:0]  op;
    logic [9:0]  addr;
    logic        unused_bits;

    logic [15:0] alu_result;
    stk_eff_t    alu_eff;
    stk_eff_t    eff;
    logic [15:0] push_val;
    stack_t      popped;

    // The instruction is only on rd_data during EXEC; LOAD still needs to
    // know which load it is finishing, so it decodes the captured copy.
    assign instr       = (phase_q == PH_EXEC) ? rd_data : ir_q;
    assign op          = instr[14:12];
    assign addr        = instr[9:0];
    assign unused_bits = ^instr[11:10];

    cpu_alu u_alu (
        .a      (stack_q[1]),
        .b      (stack_q[0]),
        .func   (instr[3:0]),
        .result (alu_result),
        .eff    (alu_eff)
    );

    // Sequencing, output muxing and selection of the stack effect.
    always_comb begin
        pc_d     = pc_q;
        phase_d  = phase_q;
        ir_d     = ir_q;
        mem_addr = pc_q;
        wr_data  = stack_q[0];
        mem_wr   = 1'b0;
        eff      = '0;
        push_val = '0;

        case (phase_q)
            PH_FETCH: phase_d = PH_EXEC;

            PH_EXEC: begin
                ir_d    = rd_data;
                phase_d = PH_FETCH;
                pc_d    = pc_q + 10'd1;
                if (instr[15]) begin
                    eff.push = 1'b1;
                    push_val = sext15(instr[14:0]);
                end else begin
                    case (op)
                        OP_ALU: begin
                            eff      = alu_eff;
                            push_val = alu_result;
                        end
                        OP_JMP: pc_d = addr;
                        OP_JZ: begin
                            eff.pop_cnt = 2'd1;
                            if (stack_q[0] == 16'h0) pc_d = addr;
                        end
                        OP_LD: begin
                            mem_addr = addr;
                            phase_d  = PH_LOAD;
                            pc_d     = pc_q;
                        end
                        OP_ST: begin
                            mem_addr    = addr;
                            mem_wr      = 1'b1;
                            eff.pop_cnt = 2'd1;
                        end
                        OP_LDI: begin
                            mem_addr = stack_q[0][9:0];
                            phase_d  = PH_LOAD;
                            pc_d     = pc_q;
                        end
                        OP_STI: begin
                            mem_addr    = stack_q[1][9:0];
                            mem_wr      = 1'b1;
                            eff.pop_cnt = 2'd2;
                        end
                        default: phase_d = PH_HALT;  // OP_HALT
                    endcase
                end
            end

            PH_LOAD: begin
                phase_d  = PH_FETCH;
                pc_d     = pc_q + 10'd1;
                eff.push = 1'b1;
                push_val = rd_data;
                // LDI replaces the top (its address) rather than pushing
                if (op == OP_LDI) eff.pop_cnt = 2'd1;
            end

            default: ;  // PH_HALT: idle until reset
        endcase

        if (rst) begin
            mem_wr   = 1'b0;
            mem_addr = pc_q;
        end
    end

    // Shift-register stack: pops shift toward the top filling zeros at the
    // bottom, pushes shift away from the top discarding the bottom entry.
    always_comb begin
        case (eff.pop_cnt)
            2'd1:    popped = {16'h0, stack_q[STACK_DEPTH-1:1]};
            2'd2:    popped = {32'h0, stack_q[STACK_DEPTH-1:2]};
            default: popped = stack_q;
        endcase
        stack_d = popped;
        if (eff.push) stack_d = {popped[STACK_DEPTH-2:0], push_val};
        if (eff.swap) begin
            stack_d[0] = stack_q[1];
            stack_d[1] = stack_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            phase_q <= PH_FETCH;
            ir_q    <= '0;
            stack_q <= '0;
        end else begin
            pc_q    <= pc_d;
            phase_q <= phase_d;
            ir_q    <= ir_d;
            stack_q <= stack_d;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: self-checking bench for cpu. A behavioural memory serves the DUT;
// every store the DUT issues is recorded with its cycle number (cycle 1 is
// the first cycle after reset release) and compared with table entries or
// with an instruction-level reference model.
module tb_cpu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  mem_addr;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic        mem_wr;

    cpu #(.RESET_PC(10'h100), .STACK_DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .rd_data  (rd_data),
        .wr_data  (wr_data),
        .mem_wr   (mem_wr)
    );

    always #5 clk = ~clk;

    // memory: img is the image loaded while load_req is high
    logic [15:0] mem [0:1023];
    logic [15:0] img [0:1023];
    logic        load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 1024; i++) mem[i] <= img[i];
        end else if (mem_wr) begin
            mem[mem_addr] <= wr_data;
        end
        rd_data <= mem[mem_addr];
    end

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [15:0] data;
    } st_t;

    st_t got[$];
    st_t expq[$];
    int  cyc;

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            got.delete();
        end else begin
            cyc++;
            if (mem_wr) got.push_back('{cyc, mem_addr, wr_data});
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // reset for two cycles (loading img), release, then run budget cycles
    task automatic run(input int budget);
        rst      = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        @(negedge clk);
        chk("rst_mem_addr", {22'h0, mem_addr}, 32'h100);
        chk("rst_mem_wr2", {31'h0, mem_wr}, 32'h0);
        load_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_fetch", {22'h0, mem_addr}, 32'h100);
        repeat (budget) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model (instruction level) ----------------
    logic [15:0] ms [0:15];

    task automatic m_push(input logic [15:0] v);
        for (int i = 15; i > 0; i--) ms[i] = ms[i-1];
        ms[0] = v;
    endtask

    task automatic m_pop(output logic [15:0] v);
        v = ms[0];
        for (int i = 0; i < 15; i++) ms[i] = ms[i+1];
        ms[15] = 16'h0;
    endtask

    task automatic m_alu(input logic [3:0] f);
        logic [15:0] a, b, r;
        case (f)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA: begin
                m_pop(b);
                m_pop(a);
                case (f)
                    4'h1:    r = a + b;
                    4'h2:    r = a - b;
                    4'h3:    r = a & b;
                    4'h4:    r = a | b;
                    4'h5:    r = a ^ b;
                    4'h7:    r = a << b[3:0];
                    4'h8:    r = a >> b[3:0];
                    4'h9:    r = (a == b) ? 16'd1 : 16'd0;
                    default: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                endcase
                m_push(r);
            end
            4'h6: ms[0] = ~ms[0];
            4'hB: m_push(ms[0]);
            4'hC: m_pop(b);
            4'hD: begin
                a = ms[0];
                ms[0] = ms[1];
                ms[1] = a;
            end
            default: ;
        endcase
    endtask

    // Executes img from 0x100 until HALT; fills expq, returns cycles used.
    task automatic run_model(output int tot);
        logic [15:0] m [0:1023];
        logic [15:0] ins, v;
        logic [9:0]  pc;
        int          t;
        bit          done;
        for (int i = 0; i < 1024; i++) m[i] = img[i];
        for (int i = 0; i < 16; i++) ms[i] = 16'h0;
        expq.delete();
        pc = 10'h100;
        t = 0;
        done = 1'b0;
        for (int step = 0; step < 4000 && !done; step++) begin
            ins = m[pc];
            if (ins[15]) begin
                m_push({ins[14], ins[14:0]});
                pc = pc + 10'd1; t += 2;
            end else begin
                case (ins[14:12])
                    3'd0: begin m_alu(ins[3:0]); pc = pc + 10'd1; t += 2; end
                    3'd1: begin pc = ins[9:0]; t += 2; end
                    3'd2: begin
                        m_pop(v);
                        pc = (v == 16'h0) ? ins[9:0] : pc + 10'd1;
                        t += 2;
                    end
                    3'd3: begin m_push(m[ins[9:0]]); pc = pc + 10'd1; t += 3; end
                    3'd4: begin
                        expq.push_back('{t + 2, ins[9:0], ms[0]});
                        m[ins[9:0]] = ms[0];
                        m_pop(v);
                        pc = pc + 10'd1; t += 2;
                    end
                    3'd5: begin ms[0] = m[ms[0][9:0]]; pc = pc + 10'd1; t += 3; end
                    3'd6: begin
                        expq.push_back('{t + 2, ms[1][9:0], ms[0]});
                        m[ms[1][9:0]] = ms[0];
                        m_pop(v);
                        m_pop(v);
                        pc = pc + 10'd1; t += 2;
                    end
                    default: done = 1'b1;
                endcase
            end
        end
        tot = t;
    endtask

    // ---------------- stimulus helpers ----------------
    int p;

    task automatic emit(input logic [15:0] w);
        img[10'h100 + 10'(p)] = w;
        p++;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 16'h0;
        img[10'h200] = 16'h1234;
        img[10'h110] = 16'h802A;  // branch landing: PUSH 0x2A, ST 0x001, HALT
        img[10'h111] = 16'h4001;
        img[10'h112] = 16'h7000;
        p = 0;
    endtask

    typedef struct {
        string           nm;
        logic [5:0][15:0] w;
        logic [15:0]     wd;
        int              cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [15:0] w0, w1, w2, w3, w4, w5,
                           input logic [15:0] wd, input int c);
        vec_t v;
        v.nm  = nm;
        v.w   = {w5, w4, w3, w2, w1, w0};
        v.wd  = wd;
        v.cyc = c;
        vecs.push_back(v);
    endtask

    task automatic gen_random();
        int k;
        logic [9:0] tgt;
        clear_img();
        for (int i = 0; i < 16; i++) img[10'h200 + 10'(i)] = 16'($urandom);
        for (int n = 0; n < 25; n++) begin
            k = $urandom_range(0, 11);
            case (k)
                0, 1, 2: emit({1'b1, 15'($urandom)});
                3:       emit({1'b1, 11'h0, 4'($urandom)});
                4, 5:    emit({12'h000, 4'($urandom)});
                6:       emit(($urandom_range(0, 1) == 0) ? 16'h4001 : {6'b010000, 6'h20, 4'($urandom)});
                7:       emit({6'b001100, 6'h20, 4'($urandom)});
                8: begin emit({6'b100000, 6'h20, 4'($urandom)}); emit(16'h5000); end
                9: begin
                    emit({6'b100000, 6'h20, 4'($urandom)});
                    emit({1'b1, 15'($urandom)});
                    emit(16'h6000);
                end
                10: begin
                    tgt = 10'h100 + 10'(p) + 10'd2;
                    emit({6'b001000, tgt});
                end
                default: begin
                    tgt = 10'h100 + 10'(p) + 10'd2;
                    emit({6'b000100, tgt});
                end
            endcase
        end
        emit(16'h7000);
        emit(16'h7000);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int tot;

        add_vec("add",      16'h8003, 16'h8004, 16'h0001, 16'h4001, 16'h7000, 16'h7000, 16'h0007, 8);
        add_vec("sub",      16'h8005, 16'h8009, 16'h0002, 16'h4001, 16'h7000, 16'h7000, 16'hFFFC, 8);
        add_vec("lt",       16'hFFFC, 16'h8001, 16'h000A, 16'h4001, 16'h7000, 16'h7000, 16'h0001, 8);
        add_vec("ld",       16'h3200, 16'h8001, 16'h0001, 16'h4001, 16'h7000, 16'h7000, 16'h1235, 9);
        add_vec("jz_taken", 16'h8000, 16'h2110, 16'h8055, 16'h4001, 16'h7000, 16'h7000, 16'h002A, 8);
        add_vec("jz_not",   16'h8001, 16'h2110, 16'h8055, 16'h4001, 16'h7000, 16'h7000, 16'h0055, 8);
        add_vec("shl",      16'h8003, 16'h8004, 16'h0007, 16'h4001, 16'h7000, 16'h7000, 16'h0030, 8);
        add_vec("shr",      16'hFFF0, 16'h8004, 16'h0008, 16'h4001, 16'h7000, 16'h7000, 16'h0FFF, 8);
        add_vec("swap_sub", 16'h8002, 16'h8007, 16'h000D, 16'h0002, 16'h4001, 16'h7000, 16'h0005, 10);
        add_vec("ldi",      16'h8200, 16'h5000, 16'h4001, 16'h7000, 16'h7000, 16'h7000, 16'h1234, 7);
        add_vec("sti",      16'h8001, 16'h8099, 16'h6000, 16'h7000, 16'h7000, 16'h7000, 16'h0099, 6);
        add_vec("jmp",      16'h1110, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h002A, 6);
        add_vec("dup_eq",   16'h8009, 16'h000B, 16'h0009, 16'h4001, 16'h7000, 16'h7000, 16'h0001, 8);
        add_vec("wrap_add", 16'hFFFF, 16'h8001, 16'h0001, 16'h4001, 16'h7000, 16'h7000, 16'h0000, 8);

        foreach (vecs[v]) begin
            clear_img();
            for (int i = 0; i < 6; i++) emit(vecs[v].w[i]);
            emit(16'h7000);
            run(40);
            chk({vecs[v].nm, "_count"}, got.size(), 1);
            if (got.size() >= 1) begin
                chk({vecs[v].nm, "_addr"}, {22'h0, got[0].addr}, 32'h001);
                chk({vecs[v].nm, "_data"}, {16'h0, got[0].data}, {16'h0, vecs[v].wd});
                chk({vecs[v].nm, "_cycle"}, got[0].cyc, vecs[v].cyc);
            end
        end

        // stack overflow: 17 pushes, 17 stores, then HALT stays quiet
        clear_img();
        for (int i = 1; i <= 17; i++) emit(16'h8000 | 16'(i));
        for (int i = 0; i < 17; i++) emit(16'h4001);
        emit(16'h7000);
        run(80);
        chk("ovf_count", got.size(), 17);
        for (int k = 0; k < 17 && k < got.size(); k++) begin
            chk("ovf_data", {16'h0, got[k].data}, (k < 16) ? 32'(17 - k) : 32'h0);
            chk("ovf_cycle", got[k].cyc, 36 + 2 * k);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_mem_wr", {31'h0, mem_wr}, 32'h0);
        end

        // randomized programs against the reference model
        for (int r = 0; r < 40; r++) begin
            gen_random();
            run_model(tot);
            run(tot + 10);
            chk("rnd_count", got.size(), expq.size());
            for (int i = 0; i < got.size() && i < expq.size(); i++) begin
                chk("rnd_addr", {22'h0, got[i].addr}, {22'h0, expq[i].addr});
                chk("rnd_data", {16'h0, got[i].data}, {16'h0, expq[i].data});
                chk("rnd_cycle", got[i].cyc, expq[i].cyc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
